// File: rtl/program_memory_loader.sv
// program_memory_loader: writable instruction memory with a registered fetch port
// and a byte-serial, XOR-checksummed loader that stalls the CPU while loading.
module program_memory_loader #(
  parameter int DATA_WIDTH = 28,
  parameter int ADDR_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_WORD = DATA_WIDTH'({8'd4, 24'd0})
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [15:0]           iAddress,
  input  logic                  iFetchEnable,
  output logic [DATA_WIDTH-1:0] oInstruction,
  output logic                  oInstructionValid,
  input  logic                  iLoadStart,
  input  logic [7:0]            iLoadByte,
  input  logic                  iLoadValid,
  output logic                  oLoadReady,
  output logic                  oBusy,
  output logic                  oLoadDone,
  output logic                  oError
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int BPW = (DATA_WIDTH + 7) / 8;
  localparam int AW = BPW * 8;
  typedef enum logic [2:0] {IDLE, HDR, DATA, CHK, DONE} state_t;
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d, xor_q, xor_d;
  logic [23:0] hdr_q, hdr_d;
  logic [15:0] wa_q, wa_d, wc_q, wc_d;
  logic [AW-1:0] asm_q, asm_d;
  logic err_q, err_d, vld_q;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic busy, xfer, in_range, last, we;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  assign busy = state_q inside {HDR, DATA, CHK};
  assign xfer = busy & iLoadValid;
  assign in_range = (wa_q >> ADDR_WIDTH) == '0;
  assign last = cnt_q == 8'(BPW - 1);
  assign we = state_q == DATA && xfer && last && in_range;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    xor_d = xfer ? xor_q ^ iLoadByte : xor_q;
    hdr_d = hdr_q;
    wa_d = wa_q;
    wc_d = wc_q;
    asm_d = asm_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (iLoadStart) begin
        state_d = HDR;
        cnt_d = '0;
        xor_d = '0;
        err_d = 1'b0;
      end
      HDR: if (xfer) begin
        hdr_d = {hdr_q[15:0], iLoadByte};
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'd3) begin
          cnt_d = '0;
          wa_d = hdr_q[23:8];
          wc_d = {hdr_q[7:0], iLoadByte};
          state_d = wc_d == '0 ? CHK : DATA;
        end
      end
      DATA: if (xfer) begin
        asm_d = AW'({asm_q, iLoadByte});
        cnt_d = last ? '0 : cnt_q + 8'd1;
        if (last) begin
          wa_d = wa_q + 16'd1;
          wc_d = wc_q - 16'd1;
          err_d = err_q | ~in_range;
          state_d = wc_q == 16'd1 ? CHK : DATA;
        end
      end
      CHK: if (xfer) begin
        err_d = err_q | (xor_d != '0);
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    // Busy or out-of-range fetches return the NOP word instead of array data
    instr_d = !iFetchEnable ? instr_q :
              (busy || (iAddress >> ADDR_WIDTH) != '0) ? DEFAULT_WORD :
              mem[iAddress[ADDR_WIDTH-1:0]];
  end
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      xor_q <= '0;
      hdr_q <= '0;
      wa_q <= '0;
      wc_q <= '0;
      asm_q <= '0;
      err_q <= 1'b0;
      instr_q <= DEFAULT_WORD;
      vld_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      xor_q <= xor_d;
      hdr_q <= hdr_d;
      wa_q <= wa_d;
      wc_q <= wc_d;
      asm_q <= asm_d;
      err_q <= err_d;
      instr_q <= instr_d;
      vld_q <= iFetchEnable;
    end
  end
  always_ff @(posedge Clock) begin
    if (we) mem[wa_q[ADDR_WIDTH-1:0]] <= asm_d[DATA_WIDTH-1:0];
  end
  assign oInstruction = instr_q;
  assign oInstructionValid = vld_q;
  assign oLoadReady = busy;
  assign oBusy = busy;
  assign oLoadDone = state_q == DONE;
  assign oError = err_q;
endmodule

// File: tb/tb_program_memory_loader.sv
// tb_program_memory_loader: directed load frames and fetches against hand-computed
// memory contents, error flags and handshake behaviour.
module tb_program_memory_loader;
  localparam logic [31:0] DEF = 32'h0400_0000;
  logic Clock = 1'b0, Reset = 1'b0;
  logic [15:0] iAddress = '0;
  logic iFetchEnable = 1'b0, iLoadStart = 1'b0, iLoadValid = 1'b0;
  logic [7:0] iLoadByte = '0;
  logic [27:0] oInstruction;
  logic oInstructionValid, oLoadReady, oBusy, oLoadDone, oError;
  int checks = 0, failures = 0, done_cnt = 0, done_exp = 0;
  logic [31:0] wd [4];

  program_memory_loader dut (
    .Clock(Clock), .Reset(Reset), .iAddress(iAddress), .iFetchEnable(iFetchEnable),
    .oInstruction(oInstruction), .oInstructionValid(oInstructionValid),
    .iLoadStart(iLoadStart), .iLoadByte(iLoadByte), .iLoadValid(iLoadValid),
    .oLoadReady(oLoadReady), .oBusy(oBusy), .oLoadDone(oLoadDone), .oError(oError)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) if (oLoadDone) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    iLoadByte = b;
    iLoadValid = 1'b1;
    while (!oLoadReady && n < 20) begin
      @(negedge Clock);
      n++;
    end
    if (n >= 20) chk("ready_timeout", 32'(oLoadReady), 32'd1);
    @(negedge Clock);
    iLoadValid = 1'b0;
  endtask

  task automatic busy_fetch();
    iAddress = 16'd2;
    iFetchEnable = 1'b1;
    @(negedge Clock);
    iFetchEnable = 1'b0;
    chk("busy_fetch", 32'(oInstruction), DEF);
  endtask

  task automatic fetch(input logic [15:0] a, input logic [31:0] exp, input string tag);
    iAddress = a;
    iFetchEnable = 1'b1;
    @(negedge Clock);
    iFetchEnable = 1'b0;
    chk({tag, "_valid"}, 32'(oInstructionValid), 32'd1);
    chk(tag, 32'(oInstruction), exp);
  endtask

  task automatic frame(input logic [15:0] sa, input logic [15:0] wc, input logic [7:0] cx,
                       input bit gaps, input int limit);
    logic [7:0] q[$];
    logic [7:0] x = '0;
    q = {sa[15:8], sa[7:0], wc[15:8], wc[7:0]};
    for (int i = 0; i < int'(wc); i++)
      for (int k = 3; k >= 0; k--) q.push_back(wd[i][8*k+:8]);
    foreach (q[i]) x ^= q[i];
    q.push_back(x ^ cx);
    @(negedge Clock);
    iLoadStart = 1'b1;
    @(negedge Clock);
    iLoadStart = 1'b0;
    chk("start_busy", 32'(oBusy), 32'd1);
    chk("start_err_clear", 32'(oError), 32'd0);
    for (int i = 0; i < q.size() && i < limit; i++) begin
      send(q[i]);
      if (gaps && i < q.size() - 1) repeat ($urandom_range(0, 5)) busy_fetch();
    end
  endtask

  task automatic finish_frame(input logic err, input string tag);
    chk({tag, "_done"}, 32'(oLoadDone), 32'd1);
    chk({tag, "_notbusy"}, 32'(oBusy), 32'd0);
    chk({tag, "_err"}, 32'(oError), 32'(err));
    done_exp++;
    @(negedge Clock);
    chk({tag, "_donecnt"}, 32'(done_cnt), 32'(done_exp));
    chk({tag, "_done_low"}, 32'(oLoadDone), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge Clock);
    chk("rst_instr", 32'(oInstruction), DEF);
    chk("rst_valid", 32'(oInstructionValid), 32'd0);
    chk("rst_ready", 32'(oLoadReady), 32'd0);
    chk("rst_busy", 32'(oBusy), 32'd0);
    chk("rst_done", 32'(oLoadDone), 32'd0);
    chk("rst_err", 32'(oError), 32'd0);
    iFetchEnable = 1'b1;
    @(negedge Clock);
    chk("rst_valid_fetch", 32'(oInstructionValid), 32'd0);
    iFetchEnable = 1'b0;
    Reset = 1'b1;
    @(negedge Clock);
    chk("post_rst_instr", 32'(oInstruction), DEF);
    // Basic frame with padding nibble in the second word
    wd[0] = 32'h0123_4567; wd[1] = 32'h0ABC_DEF0;
    frame(16'h0002, 16'd2, 8'h00, 1'b0, 1000);
    finish_frame(1'b0, "frameA");
    fetch(16'd2, 32'h0123_4567, "fetch2");
    fetch(16'd3, 32'h0ABC_DEF0, "fetch3");
    fetch(16'd300, DEF, "fetch300");
    // Corrupted checksum still writes the data
    wd[0] = 32'h0111_1111; wd[1] = 32'h0222_2222;
    frame(16'h0002, 16'd2, 8'h5A, 1'b0, 1000);
    finish_frame(1'b1, "badchk");
    fetch(16'd2, 32'h0111_1111, "badchk_fetch2");
    fetch(16'd3, 32'h0222_2222, "badchk_fetch3");
    // Overrun past the last word; start of this frame clears the sticky error
    wd[0] = 32'h0CAF_E123; wd[1] = 32'h0DEA_DBEE;
    frame(16'h00FF, 16'd2, 8'h00, 1'b0, 1000);
    finish_frame(1'b1, "overrun");
    fetch(16'd255, 32'h0CAF_E123, "fetch255");
    fetch(16'd256, DEF, "fetch256");
    // Empty frame goes straight to the checksum byte
    frame(16'h0005, 16'd0, 8'h00, 1'b0, 1000);
    finish_frame(1'b0, "wc0");
    // Valid gaps with fetches while busy
    wd[0] = 32'h0765_4321; wd[1] = 32'h0FED_CBA9;
    frame(16'h0002, 16'd2, 8'h00, 1'b1, 1000);
    finish_frame(1'b0, "gapped");
    fetch(16'd2, 32'h0765_4321, "gap_fetch2");
    fetch(16'd3, 32'h0FED_CBA9, "gap_fetch3");
    fetch(16'd255, 32'h0CAF_E123, "gap_fetch255");
    // Reset after 6 data bytes of a three-word frame
    wd[0] = 32'h0AAA_AAAA; wd[1] = 32'h0BBB_BBBB; wd[2] = 32'h0CCC_CCCC;
    frame(16'h0010, 16'd3, 8'h00, 1'b0, 10);
    chk("mid_busy", 32'(oBusy), 32'd1);
    Reset = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(oBusy), 32'd0);
    chk("mid_rst_ready", 32'(oLoadReady), 32'd0);
    @(negedge Clock);
    Reset = 1'b1;
    repeat (3) @(negedge Clock);
    chk("mid_rst_nodone", 32'(done_cnt), 32'(done_exp));
    fetch(16'h0010, 32'h0AAA_AAAA, "mid_word0");
    wd[0] = 32'h0135_7924;
    frame(16'h0011, 16'd1, 8'h00, 1'b0, 1000);
    finish_frame(1'b0, "fresh");
    fetch(16'h0011, 32'h0135_7924, "fresh_fetch");
    fetch(16'h0010, 32'h0AAA_AAAA, "fresh_word0");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/program_memory_loader.md
Name: program_memory_loader

Overview:
- Writable, parametrised instruction memory for the Spartan-3E test CPU.
- Replaces the hard-coded ROM: a registered fetch port feeds the CPU, and a byte-serial loader with a valid/ready handshake fills the array at run time.
- The loader checks each frame with an XOR checksum.
- While a load is in progress, the block stalls the CPU through oBusy.

Parameters:
- DATA_WIDTH, 28, instruction word width.
- ADDR_WIDTH, 8, array depth is DEPTH = 2**ADDR_WIDTH words.
- DEFAULT_WORD, {8'd4, 24'd0} (`NOP encoding, opcode 4), returned for out-of-range fetches and while busy.
- BPW, derived as ceil(DATA_WIDTH/8), bytes per word on the load port (4 at default).

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- iAddress  input  16  fetch address.
- iFetchEnable  input  1  capture iAddress this cycle.
- oInstruction  output  DATA_WIDTH  registered fetch data.
- oInstructionValid  output  1  oInstruction updated this cycle.
- iLoadStart  input  1  one-cycle pulse that opens a load frame.
- iLoadByte  input  8  load data byte.
- iLoadValid  input  1  iLoadByte is valid.
- oLoadReady  output  1  loader accepts a byte this cycle.
- oBusy  output  1  load frame in progress; the CPU must stall.
- oLoadDone  output  1  one-cycle pulse at the end of a frame.
- oError  output  1  sticky error; cleared by the next iLoadStart.

Behaviour:
- Reset (Reset=0, asynchronous):
  - State = IDLE; all counters = 0.
  - oInstruction = DEFAULT_WORD; oInstructionValid = 0.
  - oLoadReady = 0, oBusy = 0, oLoadDone = 0, oError = 0.
  - Array contents are not reset; they are undefined until loaded.
- Fetch:
  - Latency is 1 cycle. When iFetchEnable=1 at edge N, oInstruction holds mem[iAddress] after edge N and oInstructionValid=1 for that one cycle.
  - If iAddress >= DEPTH, or oBusy=1 at edge N, oInstruction = DEFAULT_WORD (valid still pulses).
  - When iFetchEnable=0, oInstruction holds its value.
- Byte transfer: a byte transfers only on edges where iLoadValid=1 and oLoadReady=1. oLoadReady=1 in the HDR, DATA and CHK states, 0 otherwise.
- Frame format (all fields MSB first):
  - 2 bytes: start address SA.
  - 2 bytes: word count WC.
  - WC*BPW data bytes.
  - 1 checksum byte.
- Checksum:
  - Running XOR of every header and data byte.
  - The frame passes if running XOR ^ checksum byte == 0.
- State machine:
  - IDLE: iLoadStart=1 -> HDR. Clears oError and the XOR, sets oBusy=1.
  - HDR: after 4 accepted bytes, latch SA and WC. If WC=0 -> CHK, else -> DATA.
  - DATA:
    - Shift bytes into a BPW*8 assembly register. After BPW bytes, write the low DATA_WIDTH bits to mem[wa]; padding bits above DATA_WIDTH are ignored.
    - wa starts at SA and increments by 1 per word. The 16-bit counter wraps at 65535 -> 0.
    - A write with wa >= DEPTH is dropped and sets oError (overrun); the load continues.
    - After WC words -> CHK.
  - CHK: accept 1 byte. A mismatch sets oError. -> DONE.
  - DONE (1 cycle): oLoadDone=1, oBusy=0 -> IDLE.
- iLoadStart outside IDLE is ignored; no restart mid-frame.
- Memory write port and fetch read port are independent. A fetch in the same cycle as a write reads the old data, but the fetch returns DEFAULT_WORD anyway because oBusy=1.
- Reset asserted mid-frame: return to IDLE immediately. Words already written remain; no oLoadDone pulse.
- iLoadValid stalls of any length in HDR, DATA or CHK are legal; the state and partial word are held.

Test Plan:
- Reset, then fetch address 0 with no load -> oInstruction = DEFAULT_WORD before the first fetch; oInstructionValid=0 throughout reset.
- Frame SA=0x0002, WC=2, words 0x01234567 and 0x0ABCDEF0 (top nibble padding), correct checksum:
  - oLoadDone pulses once, oError=0.
  - Fetch 2 -> 0x1234567 one cycle later; fetch 3 -> 0xABCDEF0; fetch 300 -> DEFAULT_WORD.
- Same frame with a corrupted checksum byte -> oLoadDone pulses, oError=1, data still written. The next iLoadStart clears oError.
- SA=0x00FF, WC=2 at ADDR_WIDTH=8 -> word written to 255; second word dropped; oError=1.
- Insert random iLoadValid gaps of 0-5 cycles and issue fetches during the frame -> identical memory result; all fetches return DEFAULT_WORD while oBusy=1.
- Assert Reset after 6 data bytes of a WC=3 frame -> oBusy=0 immediately, word 0 retained, no oLoadDone. A fresh frame then loads correctly.
